// File: rtl/arb_pkg.sv
// Shared constants for the round-robin grant sequencer and the downstream 2-to-4 decoder.
package arb_pkg;
   localparam int NUM_REQ      = 4;
   localparam int IDX_W        = 2;
   localparam int HOLD_MAX_DEF = 15;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request after last_ptr, wrapping modulo 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the nearest requester after last_ptr wins.
   always_comb begin
      any  = |req;
      idx  = last_ptr;
      cand = last_ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = last_ptr + IDX_W'(k);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/rr_grant_seq4.sv
// Round-robin grant sequencer with hold-until-release and a one-cycle gap between grants.
// Optional forced release after HOLD_MAX cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_grant_seq4
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int CNT_W    = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_en,
   output logic [CNT_W-1:0]   grant_count,
   output logic               timeout
);

   arb_state_e       state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] last_q;
   logic             en_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             release_d;

   rr_pick4 u_pick (
      .req      (req),
      .last_ptr (last_q),
      .any      (pick_any),
      .idx      (pick_idx)
   );

   assign release_d = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q;
   logic       tmo_q;
   logic       force_d;

   // hold_q counts completed GRANT cycles; the HOLD_MAX-th one forces release.
   assign force_d = (hold_q == 8'(HOLD_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         en_q    <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         tmo_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q <= ST_GRANT;
                  en_q    <= 1'b1;
                  idx_q   <= pick_idx;
                  cnt_q   <= cnt_q + 1'b1;
                  hold_q  <= '0;
               end
            end
            ST_GRANT: begin
               if (release_d || force_d) begin
                  state_q <= ST_IDLE;
                  en_q    <= 1'b0;
                  last_q  <= idx_q;
                  tmo_q   <= ~release_d;
               end else begin
                  hold_q  <= hold_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign timeout = tmo_q;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         en_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q <= ST_GRANT;
                  en_q    <= 1'b1;
                  idx_q   <= pick_idx;
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            ST_GRANT: begin
               if (release_d) begin
                  state_q <= ST_IDLE;
                  en_q    <= 1'b0;
                  last_q  <= idx_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign timeout = 1'b0;
`endif

   assign grant_idx   = idx_q;
   assign grant_en    = en_q;
   assign grant_count = cnt_q;

endmodule
